// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard control: load-use stall, branch flush, ID-stage forwarding
// and debug halt/step with drain. Optional load-use stall counter under HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [4:0]       exe_wa,
   input  logic             exe_wrf,
   input  logic             exe_wdc,
   input  logic [4:0]       mem_wa,
   input  logic             mem_wrf,
   input  logic [1:0]       pcsource,
   input  logic             dbg_halt_req,
   input  logic             dbg_step_req,
   input  logic             dbg_resume_req,
   input  logic             stall_clr,
   output logic             ena,
   output logic             idexe_bubble,
   output logic             ifid_flush,
   output logic [1:0]       fwda,
   output logic [1:0]       fwdb,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int DC_W = (DRAIN_CYCLES < 4) ? 2 : $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2,
      ST_STEP   = 2'd3
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [DC_W-1:0] dc_r;
   logic [DC_W-1:0] dc_nxt_s;
   logic            halted_r;
   logic            exe_load_s;
   logic            lu_s;

   // Register 0 never forwards; an EXE ALU result beats the older MEM value.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rsel,
      input logic [4:0] e_wa,
      input logic       e_wrf,
      input logic       e_wdc,
      input logic [4:0] m_wa,
      input logic       m_wrf
   );
      logic [1:0] sel;
      if (e_wrf && !e_wdc && (e_wa != 5'd0) && (rsel == e_wa)) begin
         sel = 2'b01;
      end else if (m_wrf && (m_wa != 5'd0) && (rsel == m_wa)) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Hazard detection and operand forwarding
   always_comb begin
      exe_load_s = exe_wrf && exe_wdc && (exe_wa != 5'd0);
      lu_s       = exe_load_s && ((id_use_rs && (id_rs == exe_wa)) ||
                                  (id_use_rt && (id_rt == exe_wa)));
      fwda       = fwd_sel(id_rs, exe_wa, exe_wrf, exe_wdc, mem_wa, mem_wrf);
      fwdb       = fwd_sel(id_rt, exe_wa, exe_wrf, exe_wdc, mem_wa, mem_wrf);
   end

   // Debug state register, drain counter and registered halted decode
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_RUN;
         dc_r     <= {DC_W{1'b0}};
         halted_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         dc_r     <= dc_nxt_s;
         halted_r <= (state_nxt_s == ST_HALTED);
      end
   end

   // Next-state logic; halt overrides a load-use stall in RUN
   always_comb begin
      state_nxt_s = state_r;
      dc_nxt_s    = dc_r;
      case (state_r)
         ST_RUN: begin
            if (dbg_halt_req) begin
               state_nxt_s = ST_DRAIN;
               dc_nxt_s    = DC_W'(DRAIN_CYCLES);
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (dc_r <= DC_W'(1)) begin
               state_nxt_s = ST_HALTED;
               dc_nxt_s    = {DC_W{1'b0}};
            end else begin
               dc_nxt_s    = dc_r - DC_W'(1);
            end
         end
         ST_HALTED: begin
            if (dbg_resume_req) begin
               state_nxt_s = ST_RUN;
            end else if (dbg_step_req) begin
               state_nxt_s = ST_STEP;
            end else begin
               state_nxt_s = ST_HALTED;
            end
         end
         ST_STEP: begin
            if (lu_s) begin
               state_nxt_s = ST_STEP;
            end else begin
               state_nxt_s = ST_DRAIN;
               dc_nxt_s    = DC_W'(DRAIN_CYCLES);
            end
         end
         default: begin
            state_nxt_s = ST_RUN;
            dc_nxt_s    = {DC_W{1'b0}};
         end
      endcase
   end

   // Pipeline control outputs; a redirect is not flushed while the branch itself is stalled
   always_comb begin
      ena          = 1'b0;
      idexe_bubble = 1'b1;
      ifid_flush   = 1'b0;
      case (state_r)
         ST_RUN, ST_STEP: begin
            ena          = !lu_s;
            idexe_bubble = lu_s;
            ifid_flush   = (pcsource != 2'b00) && !lu_s;
         end
         ST_DRAIN, ST_HALTED: begin
            ena          = 1'b0;
            idexe_bubble = 1'b1;
            ifid_flush   = 1'b0;
         end
         default: begin
            ena          = 1'b0;
            idexe_bubble = 1'b1;
            ifid_flush   = 1'b0;
         end
      endcase
   end

   assign halted = halted_r;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_r;
   logic             stall_inc_s;

   assign stall_inc_s = lu_s && ((state_r == ST_RUN) || (state_r == ST_STEP));

   // Saturating load-use stall counter; clear beats increment
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (stall_clr) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt = stall_cnt_r;
`else
   logic unused_stall_clr_s;

   assign unused_stall_clr_s = stall_clr;
   assign stall_cnt          = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (stall counter sized to 4 bits).
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 4;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic [4:0]       id_rs, id_rt, exe_wa, mem_wa;
   logic             id_use_rs, id_use_rt, exe_wrf, exe_wdc, mem_wrf;
   logic [1:0]       pcsource;
   logic             dbg_halt_req, dbg_step_req, dbg_resume_req, stall_clr;
   logic             ena, idexe_bubble, ifid_flush, halted;
   logic [1:0]       fwda, fwdb;
   logic [CNT_W-1:0] stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .exe_wa(exe_wa), .exe_wrf(exe_wrf), .exe_wdc(exe_wdc),
      .mem_wa(mem_wa), .mem_wrf(mem_wrf), .pcsource(pcsource),
      .dbg_halt_req(dbg_halt_req), .dbg_step_req(dbg_step_req),
      .dbg_resume_req(dbg_resume_req), .stall_clr(stall_clr),
      .ena(ena), .idexe_bubble(idexe_bubble), .ifid_flush(ifid_flush),
      .fwda(fwda), .fwdb(fwdb), .halted(halted), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      exe_wa = 5'd0; exe_wrf = 1'b0; exe_wdc = 1'b0;
      mem_wa = 5'd0; mem_wrf = 1'b0; pcsource = 2'b00;
      dbg_halt_req = 1'b0; dbg_step_req = 1'b0; dbg_resume_req = 1'b0; stall_clr = 1'b0;
   endtask

   task automatic load_use_on();
      exe_wrf = 1'b1; exe_wdc = 1'b1; exe_wa = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_halted", halted, 0);
      check("rst_cnt", stall_cnt, 0);
      check("rst_ena", ena, 1);
      check("rst_bubble", idexe_bubble, 0);
      check("rst_flush", ifid_flush, 0);
      check("rst_fwda", fwda, 0);
      check("rst_fwdb", fwdb, 0);

      // load-use on rs: one stall, then MEM forwarding
      load_use_on();
      #1;
      check("lu_ena", ena, 0);
      check("lu_bubble", idexe_bubble, 1);
      check("lu_fwda_none", fwda, 0);
      tick();
      check("lu_cnt1", stall_cnt, PERF ? 1 : 0);
      exe_wrf = 1'b0; exe_wdc = 1'b0; exe_wa = 5'd0; mem_wa = 5'd5; mem_wrf = 1'b1;
      #1;
      check("lu_next_fwda", fwda, 2'b10);
      check("lu_next_ena", ena, 1);
      check("lu_next_bubble", idexe_bubble, 0);
      idle();
      // load-use through rt, and unused rt does not stall
      exe_wrf = 1'b1; exe_wdc = 1'b1; exe_wa = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1;
      #1;
      check("lu_rt_ena", ena, 0);
      id_use_rt = 1'b0;
      #1;
      check("lu_rt_unused_ena", ena, 1);
      exe_wa = 5'd0; id_rt = 5'd0; id_use_rt = 1'b1;
      #1;
      check("lu_r0_ena", ena, 1);
      idle();

      // forwarding priority
      exe_wa = 5'd7; mem_wa = 5'd7; exe_wrf = 1'b1; mem_wrf = 1'b1;
      id_rt = 5'd7; id_use_rt = 1'b1; id_rs = 5'd3;
      #1;
      check("fwd_exe_prio", fwdb, 2'b01);
      check("fwd_a_indep", fwda, 2'b00);
      check("fwd_no_stall", ena, 1);
      exe_wa = 5'd0;
      #1;
      check("fwd_mem", fwdb, 2'b10);
      exe_wa = 5'd7; exe_wrf = 1'b0;
      #1;
      check("fwd_exe_nowrf", fwdb, 2'b10);
      id_rt = 5'd0; exe_wa = 5'd0; mem_wa = 5'd0; exe_wrf = 1'b1;
      #1;
      check("fwd_r0", fwdb, 2'b00);
      id_rs = 5'd4; exe_wa = 5'd4;
      #1;
      check("fwd_a_exe", fwda, 2'b01);
      idle();

      // branch flush
      pcsource = 2'b10;
      #1;
      check("br_flush", ifid_flush, 1);
      check("br_ena", ena, 1);
      load_use_on();
      #1;
      check("br_lu_flush", ifid_flush, 0);
      check("br_lu_ena", ena, 0);
      idle();
      #1;
      check("br_none_flush", ifid_flush, 0);

      // halt with drain; debug requests and load-use ignored while draining
      dbg_halt_req = 1'b1;
      #1;
      check("halt_req_ena", ena, 1);
      tick();
      dbg_halt_req = 1'b0; dbg_step_req = 1'b1; pcsource = 2'b01;
      #1;
      check("drain1_ena", ena, 0);
      check("drain1_bubble", idexe_bubble, 1);
      check("drain1_flush", ifid_flush, 0);
      check("drain1_halted", halted, 0);
      tick();
      dbg_step_req = 1'b0;
      load_use_on();
      #1;
      check("drain2_ena", ena, 0);
      check("drain2_halted", halted, 0);
      tick();
      idle();
      dbg_resume_req = 1'b1;
      #1;
      check("drain3_ena", ena, 0);
      check("drain3_halted", halted, 0);
      tick();
      dbg_resume_req = 1'b0;
      #1;
      check("halted1", halted, 1);
      check("halted1_ena", ena, 0);
      check("halted1_bubble", idexe_bubble, 1);
      check("halted1_cnt", stall_cnt, PERF ? 1 : 0);
      tick();
      check("halted_hold", halted, 1);

      // single step
      dbg_step_req = 1'b1;
      tick();
      dbg_step_req = 1'b0; pcsource = 2'b10;
      #1;
      check("step_halted", halted, 0);
      check("step_ena", ena, 1);
      check("step_bubble", idexe_bubble, 0);
      check("step_flush", ifid_flush, 1);
      tick();
      pcsource = 2'b00;
      check("sdrain1_ena", ena, 0);
      tick();
      check("sdrain2_ena", ena, 0);
      tick();
      check("sdrain3_ena", ena, 0);
      check("sdrain3_halted", halted, 0);
      tick();
      check("step_halted_again", halted, 1);

      // step that meets a load-use hazard stays in STEP
      dbg_step_req = 1'b1;
      tick();
      dbg_step_req = 1'b0;
      load_use_on();
      #1;
      check("steplu_ena", ena, 0);
      check("steplu_bubble", idexe_bubble, 1);
      tick();
      idle();
      #1;
      check("steplu_stay_ena", ena, 1);
      check("steplu_halted", halted, 0);
      check("steplu_cnt", stall_cnt, PERF ? 2 : 0);
      tick();
      check("steplu_drain_ena", ena, 0);
      tick();
      tick();
      check("steplu_drain_halted", halted, 0);
      tick();
      check("steplu_halted", halted, 1);

      // step and resume together: resume wins
      dbg_step_req = 1'b1; dbg_resume_req = 1'b1;
      #1;
      check("both_pre_ena", ena, 0);
      tick();
      idle();
      #1;
      check("resume_halted", halted, 0);
      check("resume_ena", ena, 1);
      tick();
      check("resume_run_ena", ena, 1);
      check("resume_run_halted", halted, 0);

      // reset during drain abandons it
      dbg_halt_req = 1'b1;
      tick();
      dbg_halt_req = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("rstdrain_pre_ena", ena, 0);
      tick();
      rst = 1'b0;
      #1;
      check("rstdrain_halted", halted, 0);
      check("rstdrain_ena", ena, 1);
      check("rstdrain_bubble", idexe_bubble, 0);
      check("rstdrain_cnt", stall_cnt, 0);
      tick();
      tick();
      tick();
      check("rstdrain_late_halted", halted, 0);
      check("rstdrain_late_ena", ena, 1);

      // counter saturation and clear
      load_use_on();
      repeat (15) tick();
      check("sat_15", stall_cnt, PERF ? 15 : 0);
      repeat (5) tick();
      check("sat_20", stall_cnt, PERF ? 15 : 0);
      stall_clr = 1'b1;
      tick();
      stall_clr = 1'b0;
      check("clr_cnt", stall_cnt, 0);
      tick();
      check("clr_then_inc", stall_cnt, PERF ? 1 : 0);
      idle();
      tick();
      check("no_lu_hold", stall_cnt, PERF ? 1 : 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
